// File: rtl/a78_pkg.sv
// Shared constants and types for the A78 cart loader: header layout, signature and FSM states.
package a78_pkg;

  localparam int HDR_LEN = 128;

  localparam logic [7:0] OFS_SIG0   = 8'd1;
  localparam logic [7:0] OFS_SIZE   = 8'd49;
  localparam logic [7:0] OFS_FLAGS  = 8'd53;
  localparam logic [7:0] OFS_REGION = 8'd57;

  // "ATARI", first character in the top byte
  localparam logic [39:0] SIG_ATARI = 40'h41_54_41_52_49;

  typedef enum logic [2:0] {
    IDLE,
    SIG,
    HDR,
    BODY,
    FINISH
  } loader_state_t;

  // Expected signature character idx (0..4) of "ATARI".
  function automatic logic [7:0] sig_byte(input logic [2:0] idx);
    logic [39:0] sh;
    sh = SIG_ATARI << (8 * idx);
    return sh[39:32];
  endfunction

endpackage

// File: rtl/a78_cart_loader.sv
// Turns the ioctl cart download into cart RAM writes, stripping and parsing an optional A78 header.
// Write path has one cycle of latency; cart metadata is published at the end of each load.
module a78_cart_loader #(
  parameter int ADDR_W   = 18,
  parameter int IOCTL_AW = 25,
  parameter int HDR_LEN  = a78_pkg::HDR_LEN
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_data,
  output logic                mem_we,
  output logic                cart_is_7800,
  output logic [31:0]         hdr_size,
  output logic [15:0]         cart_flags,
  output logic                cart_region,
  output logic [31:0]         cart_size,
  output logic                load_done,
  output logic                cart_valid,
  output logic                hdr_err,
  output logic                ovf
);
  import a78_pkg::*;

  localparam logic [IOCTL_AW-1:0] HDR_OFS  = IOCTL_AW'(HDR_LEN);
  localparam logic [IOCTL_AW-1:0] HDR_LAST = IOCTL_AW'(HDR_LEN - 1);
  localparam logic [IOCTL_AW:0]   LEN_ONE  = {{IOCTL_AW{1'b0}}, 1'b1};
  localparam logic [IOCTL_AW:0]   MAX_LEN  = {{(IOCTL_AW - ADDR_W){1'b0}}, 1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0]          OFS_SIG_END = OFS_SIG0 + 8'd4;

  loader_state_t       state;
  logic                cart_dl;
  logic                cart_dl_q;
  logic                sig_match;
  logic                sig_next;
  logic                sig_hit;
  logic                sig_range;
  logic                mode_7800;
  logic [IOCTL_AW-1:0] last_addr;
  logic [IOCTL_AW-1:0] eff_addr;
  logic [7:0]          ofs;
  logic                ofs_low;
  logic                in_range;
  logic                hdr_short;
  logic [IOCTL_AW:0]   raw_len;
  logic [IOCTL_AW:0]   pay_len;
  logic [IOCTL_AW:0]   sat_len;

  assign cart_dl   = ioctl_download && (ioctl_index != 8'd0);
  assign ofs       = ioctl_addr[7:0];
  assign ofs_low   = (ioctl_addr[IOCTL_AW-1:8] == '0);
  assign sig_range = ofs_low && (ofs >= OFS_SIG0) && (ofs <= OFS_SIG_END);
  assign sig_hit   = (ioctl_dout == sig_byte(3'(ofs - OFS_SIG0)));
  assign sig_next  = sig_match && (!sig_range || sig_hit);

  // Payload of an A78 file lands at RAM address 0, so the header length is removed in BODY.
  assign eff_addr  = (state == BODY && mode_7800) ? ioctl_addr - HDR_OFS : ioctl_addr;
  assign in_range  = (eff_addr[IOCTL_AW-1:ADDR_W] == '0);

  assign raw_len   = {1'b0, last_addr} + LEN_ONE;
  assign pay_len   = mode_7800 ? raw_len - {1'b0, HDR_OFS} : raw_len;
  assign sat_len   = (pay_len > MAX_LEN) ? MAX_LEN : pay_len;
  assign hdr_short = mode_7800 && (last_addr < HDR_OFS);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= IDLE;
      // Track the live level so a download already in progress is not taken as a new load.
      cart_dl_q    <= cart_dl;
      sig_match    <= 1'b0;
      mode_7800    <= 1'b0;
      last_addr    <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_we       <= 1'b0;
      cart_is_7800 <= 1'b0;
      hdr_size     <= '0;
      cart_flags   <= '0;
      cart_region  <= 1'b0;
      cart_size    <= '0;
      load_done    <= 1'b0;
      cart_valid   <= 1'b0;
      hdr_err      <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      cart_dl_q <= cart_dl;
      mem_we    <= 1'b0;
      load_done <= 1'b0;

      case (state)
        IDLE: begin
          if (cart_dl && !cart_dl_q) begin
            state       <= SIG;
            sig_match   <= 1'b1;
            mode_7800   <= 1'b0;
            hdr_size    <= '0;
            cart_flags  <= '0;
            cart_region <= 1'b0;
            ovf         <= 1'b0;
            hdr_err     <= 1'b0;
            last_addr   <= '0;
          end
        end

        SIG, BODY: begin
          if (!cart_dl) begin
            state <= FINISH;
          end else if (ioctl_wr) begin
            last_addr <= ioctl_addr;
            if (in_range) begin
              mem_we   <= 1'b1;
              mem_addr <= eff_addr[ADDR_W-1:0];
              mem_data <= ioctl_dout;
            end else begin
              ovf <= 1'b1;
            end
            if (state == SIG) begin
              sig_match <= sig_next;
              if (!ofs_low || ofs >= OFS_SIG_END) begin
                cart_is_7800 <= sig_next;
                mode_7800    <= sig_next;
                state        <= sig_next ? HDR : BODY;
              end
            end
          end
        end

        HDR: begin
          if (!cart_dl) begin
            state <= FINISH;
          end else if (ioctl_wr) begin
            last_addr <= ioctl_addr;
            if (ofs_low) begin
              case (ofs)
                OFS_SIZE:          hdr_size[31:24]  <= ioctl_dout;
                OFS_SIZE + 8'd1:   hdr_size[23:16]  <= ioctl_dout;
                OFS_SIZE + 8'd2:   hdr_size[15:8]   <= ioctl_dout;
                OFS_SIZE + 8'd3:   hdr_size[7:0]    <= ioctl_dout;
                OFS_FLAGS:         cart_flags[15:8] <= ioctl_dout;
                OFS_FLAGS + 8'd1:  cart_flags[7:0]  <= ioctl_dout;
                OFS_REGION:        cart_region      <= ioctl_dout[0];
                default: ;
              endcase
            end
            if (ioctl_addr >= HDR_LAST) state <= BODY;
          end
        end

        FINISH: begin
          cart_size  <= hdr_short ? '0 : 32'(sat_len);
          hdr_err    <= hdr_short;
          load_done  <= 1'b1;
          cart_valid <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a78_cart_loader.sv
// Directed bench for a78_cart_loader: raw, A78, short-header, overflow, reset and BIOS scenarios.
module tb_a78_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cart_is_7800;
  logic [31:0] hdr_size;
  logic [15:0] cart_flags;
  logic        cart_region;
  logic [31:0] cart_size;
  logic        load_done;
  logic        cart_valid;
  logic        hdr_err;
  logic        ovf;

  int total = 0;
  int bad = 0;
  int wr_errs = 0;
  int done_cnt = 0;
  logic [24:0] first_bad = '0;

  wire [112:0] all_outs = {cart_is_7800, hdr_size, cart_flags, cart_region, cart_size,
                           load_done, cart_valid, hdr_err, ovf, mem_we, mem_addr, mem_data};

  a78_cart_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .cart_is_7800   (cart_is_7800),
    .hdr_size       (hdr_size),
    .cart_flags     (cart_flags),
    .cart_region    (cart_region),
    .cart_size      (cart_size),
    .load_done      (load_done),
    .cart_valid     (cart_valid),
    .hdr_err        (hdr_err),
    .ovf            (ovf)
  );

  always #5 clk_sys = ~clk_sys;

  // A78 header image: "ATARI", size 0x00008000, flags 0x0002, region PAL.
  function automatic logic [7:0] hdr_byte(input logic [24:0] a);
    case (a)
      25'd1:   return 8'h41;
      25'd2:   return 8'h54;
      25'd3:   return 8'h41;
      25'd4:   return 8'h52;
      25'd5:   return 8'h49;
      25'd51:  return 8'h80;
      25'd54:  return 8'h02;
      25'd57:  return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // One strobe; write port is inspected one cycle later and errors are tallied in wr_errs.
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d,
                           input logic exp_we, input logic [17:0] exp_addr);
    @(negedge clk_sys);
    if (mem_we !== 1'b0) begin
      if (wr_errs == 0) first_bad = a;
      wr_errs++;
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    if (mem_we !== exp_we || (exp_we && (mem_addr !== exp_addr || mem_data !== d))) begin
      if (wr_errs == 0) first_bad = a;
      wr_errs++;
    end
  endtask

  task automatic start_load(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    wr_errs        = 0;
    first_bad      = '0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_load();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (load_done === 1'b1) done_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
  endtask

  task automatic test_raw_2600();
    start_load(8'd1);
    for (int a = 0; a < 4096; a++) send_byte(25'(a), 8'(a), 1'b1, 18'(a));
    end_load();
    total++;
    if (wr_errs !== 0) begin bad++; $display("FAIL raw_writes: errors=%0d first at addr %0d, want 0", wr_errs, first_bad); end
    total++;
    if (cart_is_7800 !== 1'b0) begin bad++; $display("FAIL raw_is7800: got %b want 0", cart_is_7800); end
    total++;
    if (cart_size !== 32'd4096) begin bad++; $display("FAIL raw_size: got %0d want 4096", cart_size); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL raw_done_pulses: got %0d want 1", done_cnt); end
    total++;
    if (cart_valid !== 1'b1) begin bad++; $display("FAIL raw_valid: got %b want 1", cart_valid); end
    total++;
    if (ovf !== 1'b0 || hdr_err !== 1'b0) begin bad++; $display("FAIL raw_flags: ovf=%b hdr_err=%b want 0 0", ovf, hdr_err); end
  endtask

  task automatic test_a78();
    start_load(8'd2);
    for (int a = 0; a < 128; a++) send_byte(25'(a), hdr_byte(25'(a)), a < 6, 18'(a));
    total++;
    if (cart_is_7800 !== 1'b1) begin bad++; $display("FAIL a78_sig_decision: got %b want 1", cart_is_7800); end
    send_byte(25'd128, 8'd128 ^ 8'h5A, 1'b1, 18'd0);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 18'd0) begin
      bad++;
      $display("FAIL a78_first_payload: we=%b addr=%0d want we=1 addr=0", mem_we, mem_addr);
    end
    for (int a = 129; a < 384; a++) send_byte(25'(a), 8'(a) ^ 8'h5A, 1'b1, 18'(a - 128));
    send_byte(25'd32895, 8'h77, 1'b1, 18'd32767);
    end_load();
    total++;
    if (wr_errs !== 0) begin bad++; $display("FAIL a78_writes: errors=%0d first at addr %0d, want 0", wr_errs, first_bad); end
    total++;
    if (hdr_size !== 32'h0000_8000) begin bad++; $display("FAIL a78_hdr_size: got %h want 00008000", hdr_size); end
    total++;
    if (cart_flags !== 16'h0002) begin bad++; $display("FAIL a78_flags: got %h want 0002", cart_flags); end
    total++;
    if (cart_region !== 1'b1) begin bad++; $display("FAIL a78_region: got %b want 1", cart_region); end
    total++;
    if (cart_size !== 32'd32768) begin bad++; $display("FAIL a78_size: got %0d want 32768", cart_size); end
    total++;
    if (hdr_err !== 1'b0 || done_cnt !== 1) begin bad++; $display("FAIL a78_done: hdr_err=%b pulses=%0d want 0 1", hdr_err, done_cnt); end
  endtask

  task automatic test_bios_hold();
    start_load(8'd0);
    for (int a = 0; a < 16; a++) send_byte(25'(a), 8'hFF, 1'b0, 18'd0);
    end_load();
    total++;
    if (wr_errs !== 0 || done_cnt !== 0) begin bad++; $display("FAIL bios_activity: write errors=%0d pulses=%0d want 0 0", wr_errs, done_cnt); end
    total++;
    if (cart_is_7800 !== 1'b1 || hdr_size !== 32'h8000 || cart_size !== 32'd32768 || cart_flags !== 16'h0002) begin
      bad++;
      $display("FAIL bios_hold: is7800=%b hdr_size=%h size=%0d flags=%h want 1 00008000 32768 0002",
               cart_is_7800, hdr_size, cart_size, cart_flags);
    end
  endtask

  task automatic test_sig_mismatch();
    logic [7:0] d;
    start_load(8'd1);
    for (int a = 0; a < 200; a++) begin
      if (a == 0 || a == 5) d = 8'h58;
      else if (a < 5)       d = hdr_byte(25'(a));
      else                  d = 8'(a);
      send_byte(25'(a), d, 1'b1, 18'(a));
    end
    end_load();
    total++;
    if (wr_errs !== 0) begin bad++; $display("FAIL mism_writes: errors=%0d first at addr %0d, want 0", wr_errs, first_bad); end
    total++;
    if (cart_is_7800 !== 1'b0) begin bad++; $display("FAIL mism_is7800: got %b want 0", cart_is_7800); end
    total++;
    if (cart_size !== 32'd200) begin bad++; $display("FAIL mism_size: got %0d want 200", cart_size); end
    total++;
    if (mem_addr !== 18'd199) begin bad++; $display("FAIL mism_last_addr: got %0d want 199", mem_addr); end
    total++;
    if (hdr_size !== 32'd0 || done_cnt !== 1) begin bad++; $display("FAIL mism_cleared: hdr_size=%h pulses=%0d want 0 1", hdr_size, done_cnt); end
  endtask

  task automatic test_hdr_short();
    start_load(8'd1);
    for (int a = 0; a < 100; a++) send_byte(25'(a), hdr_byte(25'(a)), a < 6, 18'(a));
    end_load();
    total++;
    if (hdr_err !== 1'b1) begin bad++; $display("FAIL short_hdr_err: got %b want 1", hdr_err); end
    total++;
    if (cart_size !== 32'd0) begin bad++; $display("FAIL short_size: got %0d want 0", cart_size); end
    total++;
    if (done_cnt !== 1 || cart_is_7800 !== 1'b1) begin bad++; $display("FAIL short_done: pulses=%0d is7800=%b want 1 1", done_cnt, cart_is_7800); end
    total++;
    if (wr_errs !== 0) begin bad++; $display("FAIL short_writes: errors=%0d first at addr %0d, want 0", wr_errs, first_bad); end
  endtask

  task automatic test_ovf();
    start_load(8'd1);
    for (int a = 0; a < 16; a++) send_byte(25'(a), 8'(a), 1'b1, 18'(a));
    for (int a = 262136; a < 262144; a++) send_byte(25'(a), 8'(a), 1'b1, 18'(a));
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", ovf); end
    for (int a = 262144; a < 262148; a++) send_byte(25'(a), 8'(a), 1'b0, 18'd0);
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
    send_byte(25'd299999, 8'h11, 1'b0, 18'd0);
    end_load();
    total++;
    if (wr_errs !== 0) begin bad++; $display("FAIL ovf_writes: errors=%0d first at addr %0d, want 0", wr_errs, first_bad); end
    total++;
    if (cart_size !== 32'd262144) begin bad++; $display("FAIL ovf_size: got %0d want 262144", cart_size); end
    total++;
    if (hdr_err !== 1'b0 || done_cnt !== 1) begin bad++; $display("FAIL ovf_done: hdr_err=%b pulses=%0d want 0 1", hdr_err, done_cnt); end
  endtask

  task automatic test_reset_midload();
    start_load(8'd2);
    for (int a = 0; a < 60; a++) send_byte(25'(a), hdr_byte(25'(a)), a < 6, 18'(a));
    total++;
    if (wr_errs !== 0) begin bad++; $display("FAIL rst_pre_writes: errors=%0d first at addr %0d, want 0", wr_errs, first_bad); end
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd60;
    ioctl_dout = hdr_byte(25'd60);
    reset      = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL rst_outputs: got %h want 0", all_outs); end
    wr_errs = 0;
    for (int a = 200; a < 206; a++) send_byte(25'(a), 8'hAA, 1'b0, 18'd0);
    total++;
    if (wr_errs !== 0) begin bad++; $display("FAIL rst_no_writes: errors=%0d first at addr %0d, want 0", wr_errs, first_bad); end
    end_load();
    total++;
    if (done_cnt !== 0 || all_outs !== '0) begin bad++; $display("FAIL rst_no_done: pulses=%0d outs=%h want 0 0", done_cnt, all_outs); end
    start_load(8'd0);
    for (int a = 0; a < 10; a++) send_byte(25'(a), 8'(a), 1'b0, 18'd0);
    end_load();
    total++;
    if (wr_errs !== 0 || done_cnt !== 0) begin bad++; $display("FAIL rst_bios_activity: write errors=%0d pulses=%0d want 0 0", wr_errs, done_cnt); end
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL rst_bios_outputs: got %h want 0", all_outs); end
  endtask

  initial begin
    test_reset();
    test_raw_2600();
    test_a78();
    test_bios_hold();
    test_sig_mismatch();
    test_hdr_short();
    test_ovf();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
